// File: rtl/mem_line_store.sv
// Line-granular main-memory model on bus 2: whole-line reads and writes over the shared A2/D2/C2 bus with a fixed access latency.
// Optional MEM_DUMP_EN adds an M_DUMP input that prints the whole array on its rising edge.
module mem_line_store #(
  parameter int ADDR2_BUS_SIZE = 15,
  parameter int DATA2_BUS_SIZE = 16,
  parameter int CTR2_BUS_SIZE  = 2,
  parameter int LINE_SIZE      = 16,
  parameter int MEM_LATENCY    = 100,
  parameter int SEED           = 225526
) (
  input  logic                      CLK,
  input  logic                      RESET,
  inout  wire  [ADDR2_BUS_SIZE-1:0] A2,
  inout  wire  [DATA2_BUS_SIZE-1:0] D2,
  inout  wire  [CTR2_BUS_SIZE-1:0]  C2
`ifdef MEM_DUMP_EN
  ,
  input  logic                      M_DUMP
`endif
);

  localparam int BYTES_PER_BEAT = DATA2_BUS_SIZE / 8;
  localparam int BEATS          = LINE_SIZE * 8 / DATA2_BUS_SIZE;
  localparam int NUM_LINES      = 1 << ADDR2_BUS_SIZE;
  localparam int MEM_BYTES      = NUM_LINES * LINE_SIZE;
  localparam int OFS_W          = $clog2(LINE_SIZE);
  localparam int BYTE_ADDR_W    = ADDR2_BUS_SIZE + OFS_W;
  localparam int CNT_W          = $clog2(MEM_LATENCY + 1);
  localparam int BEAT_W         = $clog2(BEATS + 1);
  localparam int BIDX_W         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LINE_W         = LINE_SIZE * 8;

  localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP        = CTR2_BUS_SIZE'(0);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
  localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RECV = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    ACK  = 3'd4
  } state_t;

  logic [7:0] mem [MEM_BYTES];

  state_t              state, state_nxt;
  logic [BEAT_W-1:0]   beat, beat_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                op_wr, op_wr_nxt;
  logic                c2_oe, c2_oe_nxt;
  logic                d2_oe, d2_oe_nxt;

  logic                latch_addr;
  logic                store_beat;
  logic [BIDX_W-1:0]   store_idx;
  logic                send_beat;
  logic [BEAT_W-1:0]   send_idx;
  logic                commit;

  logic [ADDR2_BUS_SIZE-1:0] line_q;
  logic [DATA2_BUS_SIZE-1:0] d2_q;
  logic [DATA2_BUS_SIZE-1:0] wbuf [BEATS];
  logic [LINE_W-1:0]         line_data;
  logic [BYTE_ADDR_W-1:0]    line_base;

  // Power-up image: simulation-only contents, deliberately untouched by RESET.
  initial begin : power_up_image
    integer seed_v;
    seed_v = SEED;
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem[BYTE_ADDR_W'(i)] = 8'($random(seed_v) >> 16);
    end
  end

  assign C2 = c2_oe ? C2_RESPONSE : {CTR2_BUS_SIZE{1'bz}};
  assign D2 = d2_oe ? d2_q : {DATA2_BUS_SIZE{1'bz}};

  assign line_base = {line_q, {OFS_W{1'b0}}};

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat;
    cnt_nxt    = cnt;
    op_wr_nxt  = op_wr;
    c2_oe_nxt  = c2_oe;
    d2_oe_nxt  = d2_oe;
    latch_addr = 1'b0;
    store_beat = 1'b0;
    store_idx  = beat[BIDX_W-1:0];
    send_beat  = 1'b0;
    send_idx   = beat;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        case (C2)
          C2_READ_LINE: begin
            latch_addr = 1'b1;
            op_wr_nxt  = 1'b0;
            beat_nxt   = '0;
            cnt_nxt    = CNT_W'(1);
            state_nxt  = WAIT;
          end
          C2_WRITE_LINE: begin
            latch_addr = 1'b1;
            store_beat = 1'b1;
            store_idx  = '0;
            op_wr_nxt  = 1'b1;
            beat_nxt   = BEAT_W'(1);
            cnt_nxt    = CNT_W'(1);
            state_nxt  = (BEATS > 1) ? RECV : WAIT;
            commit     = (BEATS == 1);
          end
          default: ;
        endcase
      end
      RECV: begin
        store_beat = 1'b1;
        beat_nxt   = beat + BEAT_W'(1);
        cnt_nxt    = cnt + CNT_W'(1);
        if (beat == BEAT_W'(BEATS - 1)) begin
          commit    = 1'b1;
          beat_nxt  = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(MEM_LATENCY - 1)) begin
          c2_oe_nxt = 1'b1;
          if (op_wr) begin
            state_nxt = ACK;
          end else begin
            d2_oe_nxt = 1'b1;
            send_beat = 1'b1;
            send_idx  = '0;
            beat_nxt  = BEAT_W'(1);
            state_nxt = SEND;
          end
        end
      end
      SEND: begin
        if (beat == BEAT_W'(BEATS)) begin
          c2_oe_nxt = 1'b0;
          d2_oe_nxt = 1'b0;
          beat_nxt  = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          send_beat = 1'b1;
          beat_nxt  = beat + BEAT_W'(1);
        end
      end
      ACK: begin
        c2_oe_nxt = 1'b0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        c2_oe_nxt = 1'b0;
        d2_oe_nxt = 1'b0;
        beat_nxt  = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Control registers: async reset releases the bus immediately and drops any partial write.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      beat  <= '0;
      cnt   <= '0;
      op_wr <= 1'b0;
      c2_oe <= 1'b0;
      d2_oe <= 1'b0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      cnt   <= cnt_nxt;
      op_wr <= op_wr_nxt;
      c2_oe <= c2_oe_nxt;
      d2_oe <= d2_oe_nxt;
    end
  end

  // Datapath registers carry no reset; they are qualified by the control state.
  always_ff @(posedge CLK) begin
    if (latch_addr) line_q <= A2;
    if (store_beat) wbuf[store_idx] <= D2;
    if (send_beat) begin
      for (int b = 0; b < BYTES_PER_BEAT; b++) begin
        d2_q[8*b +: 8] <= mem[line_base + BYTE_ADDR_W'(int'(send_idx) * BYTES_PER_BEAT + b)];
      end
    end
  end

  // The final beat is taken straight from D2 so the whole line lands in one edge.
  always_comb begin
    line_data = '0;
    for (int k = 0; k < BEATS - 1; k++) begin
      line_data[k*DATA2_BUS_SIZE +: DATA2_BUS_SIZE] = wbuf[k];
    end
    line_data[(BEATS-1)*DATA2_BUS_SIZE +: DATA2_BUS_SIZE] = D2;
  end

  always @(posedge CLK) begin
    if (commit && !RESET) begin
      for (int i = 0; i < LINE_SIZE; i++) begin
        mem[line_base + BYTE_ADDR_W'(i)] <= line_data[8*i +: 8];
      end
    end
  end

`ifdef MEM_DUMP_EN
  always @(posedge M_DUMP) begin
    for (int n = 0; n < NUM_LINES; n++) begin
      $write("Line #%0d: ", n);
      for (int i = 0; i < LINE_SIZE; i++) begin
        $write("%b ", mem[BYTE_ADDR_W'(n * LINE_SIZE + i)]);
      end
      $display("");
    end
  end
`endif

endmodule

// File: tb/tb_mem_line_store.sv
// Bench for mem_line_store: plays the cache on bus 2 and scoreboards returned beats against a seeded image of memory.
module tb_mem_line_store;

  localparam int AW     = 15;
  localparam int DW     = 16;
  localparam int CW     = 2;
  localparam int LS     = 16;
  localparam int LAT    = 100;
  localparam int SEED   = 225526;
  localparam int BEATS  = LS * 8 / DW;
  localparam int NBYTES = (1 << AW) * LS;

  localparam logic [CW-1:0] C2_NOP  = 2'd0;
  localparam logic [CW-1:0] C2_RESP = 2'd1;
  localparam logic [CW-1:0] C2_RD   = 2'd2;
  localparam logic [CW-1:0] C2_WR   = 2'd3;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  logic m_dump = 1'b0;

  wire [AW-1:0] A2;
  wire [DW-1:0] D2;
  wire [CW-1:0] C2;

  logic [AW-1:0] a2_drv = '0;
  logic [DW-1:0] d2_drv = '0;
  logic [CW-1:0] c2_drv = '0;
  logic          a2_en  = 1'b0;
  logic          d2_en  = 1'b0;
  logic          c2_en  = 1'b0;

  assign A2 = a2_en ? a2_drv : {AW{1'bz}};
  assign D2 = d2_en ? d2_drv : {DW{1'bz}};
  assign C2 = c2_en ? c2_drv : {CW{1'bz}};

  mem_line_store #(
    .ADDR2_BUS_SIZE(AW),
    .DATA2_BUS_SIZE(DW),
    .CTR2_BUS_SIZE (CW),
    .LINE_SIZE     (LS),
    .MEM_LATENCY   (LAT),
    .SEED          (SEED)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .A2    (A2),
    .D2    (D2),
    .C2    (C2)
`ifdef MEM_DUMP_EN
    ,
    .M_DUMP(m_dump)
`endif
  );

  always #5 CLK = ~CLK;

  logic [7:0]  img [NBYTES];
  logic [15:0] sb [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit c2_rel();
    return (C2 === {CW{1'bz}}) || (C2 === {CW{1'b0}});
  endfunction

  function automatic bit d2_rel();
    return (D2 === {DW{1'bz}}) || (D2 === {DW{1'b0}});
  endfunction

  function automatic logic [15:0] beat_of(input logic [AW-1:0] addr, input int k);
    int base;
    base = int'(addr) * LS;
    return {img[base + 2*k + 1], img[base + 2*k]};
  endfunction

  // Read one line; abort_at != 0 pulses RESET at that cycle of the transaction.
  task automatic do_read(input logic [AW-1:0] addr, input int abort_at);
    int c, nbeats;
    bit seen, done;
    logic [15:0] exp;
    for (int k = 0; k < BEATS; k++) sb.push_back(beat_of(addr, k));
    a2_drv = addr; a2_en = 1'b1;
    c2_drv = C2_RD; c2_en = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    c2_en = 1'b0; a2_en = 1'b0;
    c = 1; nbeats = 0; seen = 1'b0; done = 1'b0;
    while (!done && c < LAT + BEATS + 20) begin
      if (abort_at != 0 && c == abort_at) begin
        chk("rst_rd_busy", C2, C2_RESP);
        RESET = 1'b1;
        #1;
        chk("rst_rd_c2z", c2_rel(), 1'b1);
        chk("rst_rd_d2z", d2_rel(), 1'b1);
        @(negedge CLK);
        RESET = 1'b0;
        sb.delete();
        done = 1'b1;
      end else if (C2 === C2_RESP) begin
        if (!seen) begin
          seen = 1'b1;
          chk("rd_latency", c, LAT);
        end
        if (sb.size() > 0) begin
          exp = sb.pop_front();
          chk("rd_data", D2, exp);
        end
        nbeats++;
        c++;
        @(negedge CLK);
      end else if (seen) begin
        chk("rd_beats", nbeats, BEATS);
        chk("rd_end_c2z", c2_rel(), 1'b1);
        chk("rd_end_d2z", d2_rel(), 1'b1);
        done = 1'b1;
      end else begin
        c++;
        @(negedge CLK);
      end
    end
    if (!done) chk("rd_timeout", c, 0);
    chk("rd_sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  // Write one line; abort_after != 0 pulses RESET once that many beats were taken.
  task automatic do_write(input logic [AW-1:0] addr, input logic [LS*8-1:0] data, input int abort_after);
    int c;
    bit done;
    a2_drv = addr; a2_en = 1'b1;
    c2_drv = C2_WR; c2_en = 1'b1;
    d2_drv = data[15:0]; d2_en = 1'b1;
    for (int k = 1; k < BEATS; k++) begin
      @(negedge CLK);
      c2_en = 1'b0; a2_en = 1'b0;
      if (abort_after != 0 && k == abort_after) begin
        RESET = 1'b1;
        d2_en = 1'b0;
        #1;
        chk("rst_wr_c2z", c2_rel(), 1'b1);
        chk("rst_wr_d2z", d2_rel(), 1'b1);
        @(negedge CLK);
        RESET = 1'b0;
        return;
      end
      d2_drv = data[16*k +: 16];
    end
    @(negedge CLK);
    d2_en = 1'b0;
    for (int i = 0; i < LS; i++) img[int'(addr) * LS + i] = data[8*i +: 8];
    c = BEATS; done = 1'b0;
    while (!done && c < LAT + 20) begin
      if (C2 === C2_RESP) begin
        chk("wr_latency", c, LAT);
        chk("wr_ack_d2z", d2_rel(), 1'b1);
        @(negedge CLK);
        chk("wr_ack_len", c2_rel(), 1'b1);
        done = 1'b1;
      end else begin
        c++;
        @(negedge CLK);
      end
    end
    if (!done) chk("wr_timeout", c, 0);
  endtask

  initial begin : main
    integer seed_v;
    logic [LS*8-1:0] pat;
    seed_v = SEED;
    for (int i = 0; i < NBYTES; i++) img[i] = 8'($random(seed_v) >> 16);

    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_c2z", c2_rel(), 1'b1);
    chk("reset_d2z", d2_rel(), 1'b1);
    RESET = 1'b0;
    @(negedge CLK);

    do_read(15'h0000, 0);

    for (int i = 0; i < LS; i++) pat[8*i +: 8] = 8'(i);
    do_write(15'h1234, pat, 0);
    do_read(15'h1234, 0);

    for (int n = 0; n < 20; n++) begin
      a2_drv = AW'($urandom); a2_en = 1'b1;
      c2_drv = (n % 3 == 0) ? C2_RESP : C2_NOP;
      c2_en  = (n % 3 != 2);
      @(negedge CLK);
      chk("noise_d2z", d2_rel(), 1'b1);
    end
    c2_en = 1'b0; a2_en = 1'b0;
    @(negedge CLK);
    chk("noise_c2z", c2_rel(), 1'b1);
    do_read(15'h0005, 0);

    do_read(15'h0003, LAT + 3);
    do_read(15'h0003, 0);

    for (int i = 0; i < LS; i++) pat[8*i +: 8] = 8'($urandom);
    do_write(15'h0007, pat, 5);
    do_read(15'h0007, 0);

    for (int i = 0; i < LS; i++) pat[8*i +: 8] = 8'(i * 17 + 3);
    do_write(15'h7FFF, pat, 0);
    do_read(15'h7FFF, 0);
    do_read(15'h0000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
